// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings, states and control word for the accumulator CPU controller
package cpu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_FETCH   = 3'd0;
    localparam state_t S_DECODE  = 3'd1;
    localparam state_t S_ADDR_HI = 3'd2;
    localparam state_t S_ADDR_LO = 3'd3;
    localparam state_t S_LOAD    = 3'd4;
    localparam state_t S_STORE   = 3'd5;
    localparam state_t S_JUMP    = 3'd6;
    localparam state_t S_HALT    = 3'd7;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_ADC = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_CLR = 4'b0111;
    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_STA = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] MUX2_AC   = 2'b00;
    localparam logic [1:0] MUX2_MEM  = 2'b01;
    localparam logic [1:0] MUX2_ZERO = 2'b10;

    localparam logic [1:0] JMP_ALWAYS = 2'b00;
    localparam logic [1:0] JMP_Z      = 2'b01;
    localparam logic [1:0] JMP_C      = 2'b10;
    localparam logic [1:0] JMP_N      = 2'b11;

    typedef struct packed {
        logic       pc_wen;
        logic       dir_wen;
        logic       status_wen;
        logic       mem_wen;
        logic       temp_wen;
        logic       ins_wen;
        logic       ac_wen;
        logic       acw_mux;
        logic       ac1_mux;
        logic       pc_mux;
        logic       cin_mux;
        logic       alu_mux1;
        logic       mem_adr_mux;
        logic [1:0] alu_mux2;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    // status is {C, Z, N}
    function automatic logic jump_taken(input logic [1:0] mode, input logic [2:0] status);
        logic taken;
        case (mode)
            JMP_ALWAYS: taken = 1'b1;
            JMP_Z:      taken = status[1];
            JMP_C:      taken = status[2];
            default:    taken = status[0];
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - controller/datapath control bundle
interface cpu_controller_if;
    logic [3:0] opcode;
    logic [1:0] jmp_mode;
    logic [2:0] status;

    logic       PCWen;
    logic       DirWen;
    logic       statusWen;
    logic       MemWen;
    logic       TempWen;
    logic       InsWen;
    logic       AcWen;
    logic       AcW_mux;
    logic       Ac1_mux;
    logic       PC_mux;
    logic       Cin_mux;
    logic       ALU_mux1;
    logic       MemAdr_mux;
    logic [1:0] ALU_mux2;
    logic [1:0] ALU_op;
    logic       halted;

    modport master (
        input  opcode, jmp_mode, status,
        output PCWen, DirWen, statusWen, MemWen, TempWen, InsWen, AcWen,
               AcW_mux, Ac1_mux, PC_mux, Cin_mux, ALU_mux1, MemAdr_mux,
               ALU_mux2, ALU_op, halted
    );

    modport slave (
        output opcode, jmp_mode, status,
        input  PCWen, DirWen, statusWen, MemWen, TempWen, InsWen, AcWen,
               AcW_mux, Ac1_mux, PC_mux, Cin_mux, ALU_mux1, MemAdr_mux,
               ALU_mux2, ALU_op, halted
    );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational map from state and instruction to control word and next state
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [3:0] op_q,
    input  logic [1:0] jmp_mode,
    input  logic [2:0] status,
    output ctrl_t      ctrl,
    output state_t     next_state
);

    always_comb begin
        ctrl       = '0;
        next_state = state;
        case (state)
            S_FETCH: begin
                ctrl.ins_wen = 1'b1;
                ctrl.pc_wen  = 1'b1;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                ctrl.dir_wen = 1'b1;
                next_state   = S_FETCH;
                case (opcode)
                    OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.ac_wen     = 1'b1;
                        ctrl.status_wen = 1'b1;
                        ctrl.alu_mux2   = MUX2_AC;
                        ctrl.cin_mux    = (opcode == OP_ADC);
                        case (opcode)
                            OP_SUB:  ctrl.alu_op = ALU_SUB;
                            OP_AND:  ctrl.alu_op = ALU_AND;
                            OP_OR:   ctrl.alu_op = ALU_OR;
                            default: ctrl.alu_op = ALU_ADD;
                        endcase
                    end
                    OP_MOV: begin
                        ctrl.ac_wen   = 1'b1;
                        ctrl.alu_mux2 = MUX2_ZERO;
                        ctrl.alu_op   = ALU_ADD;
                    end
                    // alu_mux1=1 routes the zero operand, so 0 + 0 clears Ac[dst]
                    OP_CLR: begin
                        ctrl.ac_wen   = 1'b1;
                        ctrl.alu_mux1 = 1'b1;
                        ctrl.alu_mux2 = MUX2_ZERO;
                        ctrl.alu_op   = ALU_ADD;
                    end
                    OP_LDA, OP_STA, OP_JMP: next_state = S_ADDR_HI;
                    OP_HLT:                 next_state = S_HALT;
                    default:                next_state = S_FETCH;
                endcase
            end
            S_ADDR_HI: begin
                ctrl.ins_wen = 1'b1;
                ctrl.pc_wen  = 1'b1;
                next_state   = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                ctrl.temp_wen = 1'b1;
                ctrl.pc_wen   = 1'b1;
                case (op_q)
                    OP_LDA:  next_state = S_LOAD;
                    OP_STA:  next_state = S_STORE;
                    default: next_state = S_JUMP;
                endcase
            end
            S_LOAD: begin
                ctrl.mem_adr_mux = 1'b1;
                ctrl.alu_mux1    = 1'b1;
                ctrl.alu_mux2    = MUX2_MEM;
                ctrl.alu_op      = ALU_ADD;
                ctrl.acw_mux     = 1'b1;
                ctrl.ac_wen      = 1'b1;
                next_state       = S_FETCH;
            end
            S_STORE: begin
                ctrl.mem_adr_mux = 1'b1;
                ctrl.ac1_mux     = 1'b1;
                ctrl.alu_mux2    = MUX2_ZERO;
                ctrl.alu_op      = ALU_ADD;
                ctrl.mem_wen     = 1'b1;
                next_state       = S_FETCH;
            end
            S_JUMP: begin
                if (jump_taken(jmp_mode, status)) begin
                    ctrl.pc_wen = 1'b1;
                    ctrl.pc_mux = 1'b1;
                end
                next_state = S_FETCH;
            end
            default: begin
                ctrl.halted = 1'b1;
                next_state  = S_HALT;
            end
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle control unit: state and latched opcode flops around the decoder
module cpu_controller
    import cpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    cpu_controller_if.master        bus
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op_q;
    ctrl_t      ctrl;
    ctrl_t      ctrl_g;

    cpu_ctrl_decode u_decode (
        .state      (state_q),
        .opcode     (bus.opcode),
        .op_q       (op_q),
        .jmp_mode   (bus.jmp_mode),
        .status     (bus.status),
        .ctrl       (ctrl),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            op_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= bus.opcode;
        end
    end

    // Gating with rst kills any enable in the same cycle reset is asserted
    assign ctrl_g = rst ? ctrl : '0;

    assign bus.PCWen      = ctrl_g.pc_wen;
    assign bus.DirWen     = ctrl_g.dir_wen;
    assign bus.statusWen  = ctrl_g.status_wen;
    assign bus.MemWen     = ctrl_g.mem_wen;
    assign bus.TempWen    = ctrl_g.temp_wen;
    assign bus.InsWen     = ctrl_g.ins_wen;
    assign bus.AcWen      = ctrl_g.ac_wen;
    assign bus.AcW_mux    = ctrl_g.acw_mux;
    assign bus.Ac1_mux    = ctrl_g.ac1_mux;
    assign bus.PC_mux     = ctrl_g.pc_mux;
    assign bus.Cin_mux    = ctrl_g.cin_mux;
    assign bus.ALU_mux1   = ctrl_g.alu_mux1;
    assign bus.MemAdr_mux = ctrl_g.mem_adr_mux;
    assign bus.ALU_mux2   = ctrl_g.alu_mux2;
    assign bus.ALU_op     = ctrl_g.alu_op;
    assign bus.halted     = ctrl_g.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;

    logic clk;
    logic rst;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWen,DirWen,statusWen,MemWen,TempWen,InsWen,AcWen,AcW_mux,Ac1_mux,PC_mux,Cin_mux,ALU_mux1,MemAdr_mux,ALU_mux2[1:0],ALU_op[1:0],halted}
    localparam logic [17:0] PCW    = 18'(1) << 17;
    localparam logic [17:0] DIRW   = 18'(1) << 16;
    localparam logic [17:0] STW    = 18'(1) << 15;
    localparam logic [17:0] MEMW   = 18'(1) << 14;
    localparam logic [17:0] TMPW   = 18'(1) << 13;
    localparam logic [17:0] INSW   = 18'(1) << 12;
    localparam logic [17:0] ACW    = 18'(1) << 11;
    localparam logic [17:0] ACWM   = 18'(1) << 10;
    localparam logic [17:0] AC1M   = 18'(1) << 9;
    localparam logic [17:0] PCM    = 18'(1) << 8;
    localparam logic [17:0] CIN    = 18'(1) << 7;
    localparam logic [17:0] M1     = 18'(1) << 6;
    localparam logic [17:0] MADR   = 18'(1) << 5;
    localparam logic [17:0] M2MEM  = 18'(1) << 3;
    localparam logic [17:0] M2ZERO = 18'(2) << 3;
    localparam logic [17:0] ALUSUB = 18'(1) << 1;
    localparam logic [17:0] ALUAND = 18'(2) << 1;
    localparam logic [17:0] ALUOR  = 18'(3) << 1;
    localparam logic [17:0] HALT   = 18'(1);

    localparam logic [17:0] E_FETCH = PCW | INSW;
    localparam logic [17:0] E_AHI   = PCW | INSW;
    localparam logic [17:0] E_ALO   = PCW | TMPW;
    localparam logic [17:0] E_LOAD  = MADR | M1 | M2MEM | ACWM | ACW;
    localparam logic [17:0] E_STORE = MADR | AC1M | M2ZERO | MEMW;
    localparam logic [17:0] E_JTAKE = PCW | PCM;

    logic [17:0] exp_q[$];
    string       name_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    function automatic logic [17:0] observed();
        return {bus.PCWen, bus.DirWen, bus.statusWen, bus.MemWen, bus.TempWen,
                bus.InsWen, bus.AcWen, bus.AcW_mux, bus.Ac1_mux, bus.PC_mux,
                bus.Cin_mux, bus.ALU_mux1, bus.MemAdr_mux, bus.ALU_mux2,
                bus.ALU_op, bus.halted};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic logic [17:0] e  = exp_q.pop_front();
            automatic string       nm = name_q.pop_front();
            automatic logic [17:0] g  = observed();
            n_vec++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, g, e);
            end
        end
    end

    task automatic cyc(input logic r, input logic [3:0] op, input logic [1:0] jm,
                       input logic [2:0] st, input logic [17:0] e, input string nm);
        @(posedge clk);
        #1;
        rst          = r;
        bus.opcode   = op;
        bus.jmp_mode = jm;
        bus.status   = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic one_byte(input logic [3:0] op, input logic [17:0] dec, input string nm);
        cyc(1'b1, op, 2'b00, 3'b000, E_FETCH, {nm, "_fetch"});
        cyc(1'b1, op, 2'b00, 3'b000, dec,     {nm, "_decode"});
    endtask

    // Address bytes put unrelated values on opcode to show only op_q steers the path
    task automatic three_byte(input logic [3:0] op, input logic [1:0] jm, input logic [2:0] st,
                              input logic [17:0] last, input string nm);
        cyc(1'b1, op,      jm, st, E_FETCH, {nm, "_fetch"});
        cyc(1'b1, op,      jm, st, DIRW,    {nm, "_decode"});
        cyc(1'b1, 4'b0000, jm, st, E_AHI,   {nm, "_addr_hi"});
        cyc(1'b1, 4'b0001, jm, st, E_ALO,   {nm, "_addr_lo"});
        cyc(1'b1, 4'b0110, jm, st, last,    {nm, "_exec"});
    endtask

    task automatic direct(input logic [17:0] e, input string nm);
        logic [17:0] g;
        g = observed();
        n_vec++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, g, e);
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.opcode   = 4'b1111;
        bus.jmp_mode = 2'b00;
        bus.status   = 3'b000;

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 4'b1111, 2'b11, 3'b111, 18'd0, "reset_hold");

        one_byte(4'b0001, DIRW | STW | ACW,                 "add");
        one_byte(4'b0010, DIRW | STW | ACW | CIN,           "adc");
        one_byte(4'b0011, DIRW | STW | ACW | ALUSUB,        "sub");
        one_byte(4'b0100, DIRW | STW | ACW | ALUAND,        "and");
        one_byte(4'b0101, DIRW | STW | ACW | ALUOR,         "or");
        one_byte(4'b0110, DIRW | ACW | M2ZERO,              "mov");
        one_byte(4'b0111, DIRW | ACW | M1 | M2ZERO,         "clr");
        one_byte(4'b0000, DIRW,                             "nop");
        one_byte(4'b1100, DIRW,                             "illegal_c");
        one_byte(4'b1110, DIRW,                             "illegal_e");

        three_byte(4'b1000, 2'b00, 3'b000, E_LOAD,  "lda");
        three_byte(4'b1001, 2'b00, 3'b000, E_STORE, "sta");
        one_byte(4'b0000, DIRW, "after_sta");

        three_byte(4'b1010, 2'b01, 3'b010, E_JTAKE, "jmp_z_taken");
        three_byte(4'b1010, 2'b01, 3'b000, 18'd0,   "jmp_z_not");
        three_byte(4'b1010, 2'b10, 3'b100, E_JTAKE, "jmp_c_taken");
        three_byte(4'b1010, 2'b11, 3'b110, 18'd0,   "jmp_n_not");
        three_byte(4'b1010, 2'b00, 3'b000, E_JTAKE, "jmp_always");

        // Reset in the middle of LOAD must drop AcWen without waiting for a clock
        cyc(1'b1, 4'b1000, 2'b00, 3'b000, E_FETCH, "lda_rst_fetch");
        cyc(1'b1, 4'b1000, 2'b00, 3'b000, DIRW,    "lda_rst_decode");
        cyc(1'b1, 4'b0000, 2'b00, 3'b000, E_AHI,   "lda_rst_addr_hi");
        cyc(1'b1, 4'b0000, 2'b00, 3'b000, E_ALO,   "lda_rst_addr_lo");
        @(posedge clk);
        #1;
        direct(E_LOAD, "load_before_rst");
        rst = 1'b0;
        #1;
        direct(18'd0, "load_rst_drop");
        exp_q.push_back(18'd0);
        name_q.push_back("load_rst_cycle");
        cyc(1'b0, 4'b1000, 2'b00, 3'b000, 18'd0,   "load_rst_hold");
        one_byte(4'b0011, DIRW | STW | ACW | ALUSUB, "sub_after_rst");

        cyc(1'b1, 4'b1111, 2'b00, 3'b000, E_FETCH, "hlt_fetch");
        cyc(1'b1, 4'b1111, 2'b00, 3'b000, DIRW,    "hlt_decode");
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 4'(i), 2'(i), 3'(i), HALT, "halted");
        cyc(1'b0, 4'b0001, 2'b00, 3'b000, 18'd0,   "hlt_rst");
        one_byte(4'b0001, DIRW | STW | ACW, "add_after_hlt");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
